// File: rtl/poly_operand_driver.sv
// poly_operand_driver
//   Drives the serial Go/DataIn operand interface of the polynomial evaluator
//   (R = A*x^2 + B*x + C mod 256) from a single parallel request. The block
//   presents A, B, C, X in that order. Each operand gets a Go pulse that is
//   high for GO_HIGH_CYCLES cycles, followed by GO_LOW_CYCLES cycles low.
//   It then waits for a fresh ResultValid and returns DataResult on a
//   valid/ready response port. If no result arrives within TIMEOUT cycles,
//   it returns an error response instead.
//
// Ports
//   Clock, Resetn        clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_a/b/c/x [7:0]    operands, captured on the request handshake
//   Go, DataIn [7:0]     to the evaluator
//   ResultValid          from the evaluator
//   DataResult [7:0]     from the evaluator
//   rsp_valid/rsp_ready  response handshake
//   rsp_data [7:0]       result (0 on timeout)
//   rsp_err              1 = timeout, no result seen
//   busy                 high whenever not idle
//   All outputs are registered.
module poly_operand_driver #(
   parameter int GO_HIGH_CYCLES = 2,
   parameter int GO_LOW_CYCLES  = 2,
   parameter int TIMEOUT        = 32
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic [7:0] req_c,
   input  logic [7:0] req_x,
   output logic       Go,
   output logic [7:0] DataIn,
   input  logic       ResultValid,
   input  logic [7:0] DataResult,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy
);

   localparam int CMAX01 = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
   localparam int CMAX   = (CMAX01 > TIMEOUT) ? CMAX01 : TIMEOUT;
   localparam int CW     = $clog2(CMAX + 1);

   localparam logic [CW-1:0] HI_LAST = CW'(GO_HIGH_CYCLES - 1);
   localparam logic [CW-1:0] LO_LAST = CW'(GO_LOW_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DRIVE = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]      state;
   logic [1:0]      idx;
   logic [CW-1:0]   cnt;
   logic [3:0][7:0] ops;
   // Previous ResultValid sample. The result is taken only on a 0->1 change,
   // so a level left high by an earlier result cannot be mistaken for a new one.
   logic            rv_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state     <= S_IDLE;
         idx       <= 2'd0;
         cnt       <= '0;
         ops       <= '0;
         rv_q      <= 1'b0;
         Go        <= 1'b0;
         DataIn    <= 8'd0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'd0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         rv_q <= ResultValid;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  ops       <= {req_x, req_c, req_b, req_a};
                  DataIn    <= req_a;
                  Go        <= 1'b1;
                  idx       <= 2'd0;
                  cnt       <= '0;
                  state     <= S_DRIVE;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_DRIVE: begin
               if (cnt == HI_LAST) begin
                  Go    <= 1'b0;
                  cnt   <= '0;
                  state <= S_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == LO_LAST) begin
                  cnt <= '0;
                  if (idx == 2'd3) begin
                     DataIn <= 8'd0;
                     state  <= S_WAIT;
                  end else begin
                     idx    <= idx + 2'd1;
                     DataIn <= ops[idx + 2'd1];
                     Go     <= 1'b1;
                     state  <= S_DRIVE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (ResultValid && !rv_q) begin
                  rsp_data  <= DataResult;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (cnt == TO_LAST) begin
                  rsp_data  <= 8'd0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               // req_ready rises only after this edge, so a new request can be
               // accepted on the following edge at the earliest.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               Go        <= 1'b0;
               DataIn    <= 8'd0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_operand_driver.sv
// Testbench for poly_operand_driver. The bench uses two driver/evaluator pairs.
// Pair 0 uses the default timing (2 cycles high, 2 cycles low). Pair 1 uses
// the fast timing (1 cycle high, 1 cycle low). Each pair has a small
// behavioural evaluator. That evaluator can be stubbed so that ResultValid
// stays 0, or forced so that ResultValid stays 1.
module tb_poly_operand_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic       stub_rv;
   logic       force_hi;
   logic       req_valid [2];
   logic       req_ready [2];
   logic [7:0] ra [2];
   logic [7:0] rb [2];
   logic [7:0] rc [2];
   logic [7:0] rx [2];
   logic       go [2];
   logic [7:0] din [2];
   logic       rv [2];
   logic [7:0] dres [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [7:0] rsp_data [2];
   logic       rsp_err [2];
   logic       busy [2];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_pair
      localparam int HL = (g == 0) ? 2 : 1;

      logic       ev_go_q;
      logic [1:0] ev_n;
      logic [7:0] ev_op [4];
      logic [2:0] ev_lat;
      logic       ev_rv;
      logic [7:0] ev_res;

      poly_operand_driver #(
         .GO_HIGH_CYCLES(HL),
         .GO_LOW_CYCLES (HL),
         .TIMEOUT       (32)
      ) u_dut (
         .Clock      (clk),
         .Resetn     (rstn),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_a      (ra[g]),
         .req_b      (rb[g]),
         .req_c      (rc[g]),
         .req_x      (rx[g]),
         .Go         (go[g]),
         .DataIn     (din[g]),
         .ResultValid(rv[g]),
         .DataResult (dres[g]),
         .rsp_valid  (rsp_valid[g]),
         .rsp_ready  (rsp_ready[g]),
         .rsp_data   (rsp_data[g]),
         .rsp_err    (rsp_err[g]),
         .busy       (busy[g])
      );

      // Evaluator model: it captures DataIn on each Go rise. The first operand
      // clears the previous ResultValid. The result appears a few cycles
      // after the fourth operand and stays high until the next operand set.
      always @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            ev_go_q <= 1'b0;
            ev_n    <= 2'd0;
            ev_lat  <= 3'd0;
            ev_rv   <= 1'b0;
            ev_res  <= 8'd0;
            for (int i = 0; i < 4; i++) ev_op[i] <= 8'd0;
         end else begin
            ev_go_q <= go[g];
            if (go[g] && !ev_go_q) begin
               ev_op[ev_n] <= din[g];
               ev_n        <= ev_n + 2'd1;
               if (ev_n == 2'd0) ev_rv <= 1'b0;
               if (ev_n == 2'd3) ev_lat <= 3'd4;
            end
            if (ev_lat != 3'd0) begin
               ev_lat <= ev_lat - 3'd1;
               if (ev_lat == 3'd1) begin
                  ev_rv  <= 1'b1;
                  ev_res <= ev_op[0] * ev_op[3] * ev_op[3] + ev_op[1] * ev_op[3] + ev_op[2];
               end
            end
         end
      end

      assign rv[g]   = force_hi | (ev_rv & ~stub_rv);
      assign dres[g] = ev_res;
   end

   // Called at a negedge. The request is presented there and accepted at the
   // next posedge once req_ready is seen. The task returns one cycle after the
   // accept edge, with req_valid dropped.
   task automatic start_req(input int u, input logic [7:0] a, b, c, x);
      int n;
      req_valid[u] = 1'b1;
      ra[u] = a; rb[u] = b; rc[u] = c; rx[u] = x;
      n = 0;
      while (!req_ready[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready[u] !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait u=%0d: req_ready=%b, required 1 within 50 cycles", u, req_ready[u]);
      end
      @(negedge clk);
      req_valid[u] = 1'b0;
   endtask

   task automatic trace_ops(input int u, input logic [7:0] a, b, c, x, input int hi, input int lo);
      logic [7:0] op [4];
      logic       eg;
      logic [7:0] ed;
      op[0] = a; op[1] = b; op[2] = c; op[3] = x;
      for (int k = 0; k < 4 * (hi + lo); k++) begin
         eg = ((k % (hi + lo)) < hi);
         ed = op[k / (hi + lo)];
         checks++;
         if (go[u] !== eg || din[u] !== ed || busy[u] !== 1'b1) begin
            errors++;
            $display("FAIL operand_wave u=%0d k=%0d: go=%b din=%h busy=%b, required go=%b din=%h busy=1",
                     u, k, go[u], din[u], busy[u], eg, ed);
         end
         @(negedge clk);
      end
      checks++;
      if (go[u] !== 1'b0 || din[u] !== 8'd0 || busy[u] !== 1'b1 || rsp_valid[u] !== 1'b0) begin
         errors++;
         $display("FAIL wait_entry u=%0d: go=%b din=%h busy=%b rsp_valid=%b, required 0 00 1 0",
                  u, go[u], din[u], busy[u], rsp_valid[u]);
      end
   endtask

   task automatic wait_rsp(input int u, input logic [7:0] exp_d, input logic exp_e, input int exp_wait);
      int n;
      n = 0;
      while (!rsp_valid[u] && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_data[u] !== exp_d || rsp_err[u] !== exp_e) begin
         errors++;
         $display("FAIL response u=%0d: valid=%b data=%h err=%b, required 1 %h %b",
                  u, rsp_valid[u], rsp_data[u], rsp_err[u], exp_d, exp_e);
      end
      if (exp_wait >= 0) begin
         checks++;
         if (n != exp_wait) begin
            errors++;
            $display("FAIL wait_cycles u=%0d: waited %0d, required %0d", u, n, exp_wait);
         end
      end
   endtask

   task automatic ack(input int u);
      rsp_ready[u] = 1'b1;
      @(negedge clk);
      rsp_ready[u] = 1'b0;
      checks++;
      if (rsp_valid[u] !== 1'b0 || busy[u] !== 1'b0 || req_ready[u] !== 1'b1) begin
         errors++;
         $display("FAIL handshake u=%0d: rsp_valid=%b busy=%b req_ready=%b, required 0 0 1",
                  u, rsp_valid[u], busy[u], req_ready[u]);
      end
   endtask

   task automatic run_txn(input int u, input logic [7:0] a, b, c, x, input int hl,
                          input logic [7:0] exp_d, input logic exp_e, input int exp_wait);
      @(negedge clk);
      start_req(u, a, b, c, x);
      trace_ops(u, a, b, c, x, hl, hl);
      wait_rsp(u, exp_d, exp_e, exp_wait);
      ack(u);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (go[u] !== 1'b0 || din[u] !== 8'd0 || rsp_valid[u] !== 1'b0 || rsp_data[u] !== 8'd0 ||
             rsp_err[u] !== 1'b0 || busy[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state u=%0d: go=%b din=%h rv=%b rd=%h re=%b busy=%b, required all 0",
                     u, go[u], din[u], rsp_valid[u], rsp_data[u], rsp_err[u], busy[u]);
         end
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || go[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: req_ready=%b busy=%b go=%b, required 1 0 0",
                  req_ready[0], busy[0], go[0]);
      end
   endtask

   task automatic test_basic();
      run_txn(0, 8'd1, 8'd2, 8'd3, 8'd4, 2, 8'h1B, 1'b0, -1);
   endtask

   // The second request starts while ResultValid is still high from the first.
   task automatic test_back_to_back();
      run_txn(0, 8'd3, 8'd5, 8'd7, 8'd10, 2, 8'h65, 1'b0, -1);
      run_txn(0, 8'd0, 8'd0, 8'd9, 8'd0, 2, 8'h09, 1'b0, -1);
   endtask

   // A constant-high ResultValid has no rising edge, so it must time out.
   task automatic test_stuck_high();
      force_hi = 1'b1;
      run_txn(0, 8'd1, 8'd1, 8'd1, 8'd1, 2, 8'h00, 1'b1, 32);
      force_hi = 1'b0;
   endtask

   task automatic test_timeout();
      stub_rv = 1'b1;
      run_txn(0, 8'd5, 8'd6, 8'd7, 8'd8, 2, 8'h00, 1'b1, 32);
      stub_rv = 1'b0;
   endtask

   task automatic test_resp_hold();
      @(negedge clk);
      start_req(0, 8'd1, 8'd2, 8'd3, 8'd4);
      trace_ops(0, 8'd1, 8'd2, 8'd3, 8'd4, 2, 2);
      wait_rsp(0, 8'h1B, 1'b0, -1);
      req_valid[0] = 1'b1;
      ra[0] = 8'd3; rb[0] = 8'd5; rc[0] = 8'd7; rx[0] = 8'd10;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 8'h1B || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL resp_hold i=%0d: valid=%b data=%h err=%b req_ready=%b, required 1 1b 0 0",
                     i, rsp_valid[0], rsp_data[0], rsp_err[0], req_ready[0]);
         end
         @(negedge clk);
      end
      ack(0);
      // The pending request must still be waiting (not accepted at the handshake edge).
      start_req(0, 8'd3, 8'd5, 8'd7, 8'd10);
      trace_ops(0, 8'd3, 8'd5, 8'd7, 8'd10, 2, 2);
      wait_rsp(0, 8'h65, 1'b0, -1);
      ack(0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_req(0, 8'd1, 8'd2, 8'd3, 8'd4);
      repeat (8) @(negedge clk);
      checks++;
      if (go[0] !== 1'b1 || din[0] !== 8'd3) begin
         errors++;
         $display("FAIL third_drive: go=%b din=%h, required 1 03", go[0], din[0]);
      end
      #1 rstn = 1'b0;
      #1;
      checks++;
      if (go[0] !== 1'b0 || din[0] !== 8'd0 || busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: go=%b din=%h busy=%b rsp_valid=%b, required 0 00 0 0",
                  go[0], din[0], busy[0], rsp_valid[0]);
      end
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      run_txn(0, 8'd1, 8'd2, 8'd3, 8'd4, 2, 8'h1B, 1'b0, -1);
   endtask

   task automatic test_fast_timing();
      run_txn(1, 8'd1, 8'd2, 8'd3, 8'd4, 1, 8'h1B, 1'b0, -1);
   endtask

   initial begin
      stub_rv  = 1'b0;
      force_hi = 1'b0;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 1'b0;
         rsp_ready[u] = 1'b0;
         ra[u] = 8'd0; rb[u] = 8'd0; rc[u] = 8'd0; rx[u] = 8'd0;
      end
      test_reset();
      test_basic();
      test_back_to_back();
      test_stuck_high();
      test_timeout();
      test_resp_hold();
      test_reset_mid();
      test_fast_timing();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
